button_event: RTL and testbench

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_event.sv | 173 +++++++++++++++++
 tb/tb_button_event.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// Button event classifier: turns a debounced button level into single-click,
// double-click and long-press pulses, plus a held level and a busy flag.
//
// Ports:
//   i_clk      system clock, all state changes on its rising edge
//   i_reset_n  asynchronous active-low reset
//   i_btn      debounced button level, 1 = pressed, synchronous to i_clk
//   o_single   one-cycle pulse, single click recognised
//   o_double   one-cycle pulse, double click recognised
//   o_long     one-cycle pulse, long press recognised
//   o_held     level, high while a recognised long press is still held
//   o_busy     level, high whenever the FSM is not idle
module button_event #(
    parameter int unsigned CLOCK_RATE = 16_000_000,
    parameter int unsigned LONG_MS    = 500,
    parameter int unsigned GAP_MS     = 250
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_single,
    output logic o_double,
    output logic o_long,
    output logic o_held,
    output logic o_busy
);

    localparam int unsigned TICKS_PER_MS = CLOCK_RATE / 1000;
    localparam int unsigned LONG_TICKS   = TICKS_PER_MS * LONG_MS;
    localparam int unsigned GAP_TICKS    = TICKS_PER_MS * GAP_MS;

    // One counter serves both the long-press and the release-gap timeouts,
    // so it is sized for the larger of the two.
    localparam int unsigned MAX_TICKS =
        (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
    localparam int unsigned CNT_W = $clog2(MAX_TICKS);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        LONG
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic single_q;
    logic single_d;
    logic double_q;
    logic double_d;
    logic long_q;
    logic long_d;
    logic held_q;
    logic held_d;
    logic busy_q;
    logic busy_d;

    // Next-state and pulse decode. In every branch the button edge is
    // tested before the counter, so an edge that coincides with expiry
    // wins and the timeout is not taken.
    always_comb begin
        state_d  = state_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_btn) begin
                    state_d = PRESS1;
                end
            end

            PRESS1: begin
                if (!i_btn) begin
                    state_d = GAP;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end

            GAP: begin
                if (i_btn) begin
                    state_d = PRESS2;
                end else if (cnt_q == GAP_LAST) begin
                    state_d  = IDLE;
                    single_d = 1'b1;
                end
            end

            PRESS2: begin
                if (!i_btn) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end

            LONG: begin
                if (!i_btn) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter restarts on any state change and saturates rather than
    // wrapping, so a button left in LONG never re-arms a timeout.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Levels are taken from the next state so they line up with the
    // pulses: o_held rises in the same cycle as o_long.
    always_comb begin
        held_d = (state_d == LONG);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            held_q   <= held_d;
            busy_q   <= busy_d;
        end
    end

    assign o_single = single_q;
    assign o_double = double_q;
    assign o_long   = long_q;
    assign o_held   = held_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: expected pulses (kind, cycle) are queued when the
// stimulus is driven and matched against the pulses the DUT emits.
module tb_button_event;

    localparam int K_SINGLE = 1;
    localparam int K_DOUBLE = 2;
    localparam int K_LONG   = 3;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic btn;
    logic o_single;
    logic o_double;
    logic o_long;
    logic o_held;
    logic o_busy;

    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t expq[$];
    exp_t mon_e;
    int   mon_kind;

    button_event #(
        .CLOCK_RATE(1000),
        .LONG_MS   (10),
        .GAP_MS    (5)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_btn    (btn),
        .o_single (o_single),
        .o_double (o_double),
        .o_long   (o_long),
        .o_held   (o_held),
        .o_busy   (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        expq.push_back(e);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int p);
        btn = 1'b1;
        tick(p);
        btn = 1'b0;
    endtask

    task automatic check_outs_zero(input string tag);
        check(tag, int'({o_single, o_double, o_long, o_held, o_busy}), 0);
    endtask

    // A press of p edges entered at cycle a: release reaches GAP at a+p+1
    // and the gap times out five edges later; p >= 11 goes long at a+11.
    task automatic do_single(input int p);
        int a;
        a = cyc;
        if (p <= 10) expect_pulse(K_SINGLE, a + p + 6);
        else         expect_pulse(K_LONG, a + 11);
        press(p);
        tick(12);
        check("single_idle_busy", int'(o_busy), 0);
    endtask

    // Two presses with g released edges between them. A gap of up to five
    // edges joins them into a double; six lets the first time out.
    task automatic do_double(input int p1, input int g, input int p2,
                             input int tail);
        int a;
        int c;
        a = cyc;
        c = a + p1 + g;
        if (g <= 5) begin
            if (p2 <= 10) expect_pulse(K_DOUBLE, c + p2 + 1);
            else          expect_pulse(K_LONG, c + 11);
        end else begin
            expect_pulse(K_SINGLE, a + p1 + 6);
            expect_pulse(K_SINGLE, c + p2 + 6);
        end
        press(p1);
        tick(g);
        press(p2);
        tick(tail);
    endtask

    // Every pulse is matched to the oldest expectation, both in kind and
    // in the cycle it appears; a stretched pulse shows up as extra ones.
    always @(negedge clk) begin
        if (rst_n && (o_single || o_double || o_long)) begin
            check("onehot", $countones({o_single, o_double, o_long}), 1);
            mon_kind = o_single ? K_SINGLE : (o_double ? K_DOUBLE : K_LONG);
            if (expq.size() == 0) begin
                check("unexpected_pulse", mon_kind, 0);
            end else begin
                mon_e = expq.pop_front();
                check("pulse_kind", mon_kind, mon_e.kind);
                check("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        btn   = 1'b1;
        #1;
        check_outs_zero("reset_outs_t0");
        tick(3);
        check_outs_zero("reset_outs_held");

        // Button already down at reset release: fresh press, then a click.
        a = cyc;
        expect_pulse(K_SINGLE, a + 3 + 6);
        #2 rst_n = 1'b1;
        #1;
        check("busy_before_edge", int'(o_busy), 0);
        tick(1);
        check("busy_after_release", int'(o_busy), 1);
        tick(2);
        btn = 1'b0;
        tick(12);
        check("busy_idle_1", int'(o_busy), 0);

        do_single(3);
        do_double(3, 2, 3, 14);
        check("double_idle_busy", int'(o_busy), 0);

        // Long hold with o_held window.
        a = cyc;
        expect_pulse(K_LONG, a + 11);
        btn = 1'b1;
        tick(10);
        check("held_before_long", int'(o_held), 0);
        tick(1);
        check("held_at_long", int'(o_held), 1);
        check("busy_in_long", int'(o_busy), 1);
        tick(4);
        check("held_still", int'(o_held), 1);
        btn = 1'b0;
        tick(1);
        check("held_released", int'(o_held), 0);
        check("busy_after_long", int'(o_busy), 0);
        tick(10);

        do_single(10);
        do_single(11);
        do_double(3, 5, 3, 14);
        do_double(3, 6, 3, 16);
        do_double(2, 1, 10, 14);
        do_double(2, 1, 11, 14);

        // A third press right after a double starts a new sequence.
        do_double(3, 2, 3, 1);
        do_single(4);

        // Reset in PRESS2 abandons the double.
        press(3);
        tick(2);
        btn = 1'b1;
        tick(2);
        check("busy_in_press2", int'(o_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_outs_zero("reset_async_outs");
        btn = 1'b0;
        tick(3);
        #2 rst_n = 1'b1;
        tick(12);
        check("busy_after_abort", int'(o_busy), 0);
        do_single(3);

        tick(5);
        check("queue_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
